dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the word-addressed data_memory (6-bit word address, 32-bit data, busywait handshake).
- Hits are serviced without stalling.
- Misses stall the CPU via cpu_busywait while the FSM writes back a dirty victim line and refills the line, one memory word transfer at a time.

Parameters:
- LINES, 8, number of cache lines (power of 2).
- WORDS_PER_LINE, 2, words per line (power of 2).
- ADDR_WIDTH, 6, word-address width on both CPU and memory sides.
- DATA_WIDTH, 32, word width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_read  in  1  load request; held until cpu_busywait is low.
- cpu_write  in  1  store request; held until cpu_busywait is low.
- cpu_address  in  ADDR_WIDTH  word address; split as {tag, index, offset}.
- cpu_writedata  in  DATA_WIDTH  store data.
- cpu_readdata  out  DATA_WIDTH  load data; valid when cpu_read=1 and cpu_busywait=0.
- cpu_busywait  out  1  stall to CPU.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_WIDTH  memory word address.
- mem_writedata  out  DATA_WIDTH  memory write data.
- mem_readdata  in  DATA_WIDTH  memory read data.
- mem_busywait  in  1  memory busy.

Behaviour:
- Address split:
  - offset = low log2(WORDS_PER_LINE) bits, index = next log2(LINES) bits, tag = the rest.
  - Defaults: offset [0], index [3:1], tag [5:4].
- Per-line storage: valid bit, dirty bit, tag, WORDS_PER_LINE data words.
- Reset (asynchronous):
  - All valid and dirty bits cleared; FSM to IDLE; word counter = 0.
  - mem_read, mem_write, cpu_busywait = 0; mem_address, mem_writedata, cpu_readdata = 0.
  - Data and tag arrays need not be cleared.
- hit = valid[index] && (tag_array[index] == tag).
- FSM states: IDLE, WRITEBACK, FETCH.
- IDLE:
  - cpu_read or cpu_write alone, hit:
    - cpu_busywait = 0 combinationally.
    - Read: cpu_readdata = line word[offset] combinationally, zero cycles.
    - Write: word[offset] = cpu_writedata and dirty = 1 at the next rising edge.
  - Request with miss:
    - cpu_busywait = 1 combinationally.
    - Next edge: go to WRITEBACK if the victim is valid and dirty, else FETCH; word counter = 0.
  - cpu_read and cpu_write both high: illegal. No access, cpu_busywait = 0, no memory activity.
  - Neither high: cpu_busywait = 0, no state change.
- WRITEBACK:
  - Outputs: mem_write = 1, mem_address = {victim_tag, index, cnt}, mem_writedata = line word[cnt].
  - A word transfer completes at the first rising edge where mem_busywait = 0 and the strobe has been high for at least one prior edge. The counter then increments.
  - Changing mem_address while the strobe stays high starts the next word.
  - After the last word: counter = 0, go to FETCH.
- FETCH:
  - Outputs: mem_read = 1, mem_address = {tag, index, cnt}.
  - On each word completion (same rule as WRITEBACK): line word[cnt] = mem_readdata, counter increments.
  - After the last word: valid = 1, dirty = 0, tag written, strobes low, go to IDLE.
  - The held request is then re-evaluated as a hit and completes as above.
- cpu_busywait = 1 throughout WRITEBACK and FETCH.
- CPU inputs must stay stable while cpu_busywait = 1; the controller does not re-latch them.
- Memory strobes are never both high. Strobes are 0 in IDLE.
- Reset mid-WRITEBACK or mid-FETCH:
  - Immediate abort; strobes drop asynchronously.
  - All lines invalid; a partially written memory line is acceptable.
- Counter width = log2(WORDS_PER_LINE); it wraps to 0 after the last word.

Decomposition:
- Package dcache_pkg holds:
  - FSM state enum (IDLE, WRITEBACK, FETCH).
  - Derived width constants: OFFSET_W, INDEX_W, TAG_W.
  - Address-field extract functions.
- Sub-module dcache_line_store holds the data, tag, valid and dirty arrays:
  - Combinational read ports.
  - Synchronous write port for words.
  - Fill/clean port.
  - Asynchronous clear of valid and dirty bits.
- dcache_controller holds the FSM, counter and hit logic.

Test Plan:
- Read miss after reset, cold:
  - Stimulus: reset, then cpu_read at 6'h05.
  - Response: cpu_busywait=1; exactly two mem_read transfers at 6'h04 then 6'h05; no mem_write; then cpu_busywait=0 and cpu_readdata=32'h0.
- Write hit:
  - Stimulus: line 6'h04/05 resident; cpu_write 6'h05 with 32'hDEADBEEF, then cpu_read 6'h05.
  - Response: cpu_busywait never asserted; no memory strobes; readback 32'hDEADBEEF.
- Dirty eviction:
  - Stimulus: then cpu_read 6'h15 (same index 3'b010, tag 2'b01).
  - Response: mem_write 6'h04=0, then 6'h05=32'hDEADBEEF; then mem_read 6'h14, then 6'h15.
  - Follow-up: cpu_read 6'h05 again returns 32'hDEADBEEF after a clean refill with no mem_write.
- Clean eviction:
  - Stimulus: read 6'h00, then read 6'h30 (same index 0).
  - Response: no mem_write; two mem_read transfers at 6'h30 and 6'h31.
- Reset mid-FETCH:
  - Stimulus: assert reset during the second FETCH word.
  - Response: mem_read=0 and cpu_busywait=0 immediately; the next cpu_read of the same address misses again.
- Illegal request:
  - Stimulus: cpu_read=1 and cpu_write=1 together.
  - Response: cpu_busywait=0; no memory strobes; cache contents unchanged.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// Geometry (lines, words per line, address/data widths), the derived address
// field widths, the controller FSM state type and address split/join helpers.
package dcache_pkg;

    localparam int unsigned LINES          = 8;
    localparam int unsigned WORDS_PER_LINE = 2;
    localparam int unsigned ADDR_WIDTH     = 6;
    localparam int unsigned DATA_WIDTH     = 32;

    localparam int unsigned OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned INDEX_W  = $clog2(LINES);
    localparam int unsigned TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;

    typedef logic [ADDR_WIDTH-1:0]                     addr_t;
    typedef logic [DATA_WIDTH-1:0]                     word_t;
    typedef logic [TAG_W-1:0]                          tag_t;
    typedef logic [INDEX_W-1:0]                        index_t;
    typedef logic [OFFSET_W-1:0]                       offset_t;
    typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_WIDTH-1 -: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_W-1:0];
    endfunction

    function automatic addr_t make_addr(input tag_t t, input index_t i, input offset_t o);
        return {t, i, o};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Word-addressed load/store bus with busywait handshake. Used on both sides
// of the cache: the CPU port (cache is slave) and the memory port (cache is
// master).
//   read, write  request strobes (master -> slave)
//   address      word address    (master -> slave)
//   writedata    store data      (master -> slave)
//   readdata     load data       (slave -> master)
//   busywait     stall           (slave -> master)
interface dcache_if;

    logic                             read;
    logic                             write;
    logic [dcache_pkg::ADDR_WIDTH-1:0] address;
    logic [dcache_pkg::DATA_WIDTH-1:0] writedata;
    logic [dcache_pkg::DATA_WIDTH-1:0] readdata;
    logic                             busywait;

    modport master (output read, write, address, writedata, input readdata, busywait);
    modport slave  (input read, write, address, writedata, output readdata, busywait);

endinterface

// File: rtl/dcache_line_store.sv
// Cache line storage: per-line valid, dirty, tag and data words.
//   clock, reset            clock; asynchronous active-high clear of valid/dirty
//   index                   line selected for both reads and writes
//   line_valid/dirty/tag    combinational read of the selected line's state
//   line_data               combinational read of all words of the line
//   word_we, word_offset,
//   word_data, set_dirty    synchronous single-word write, optionally marking dirty
//   fill, fill_tag          marks the line valid and clean and installs its tag
module dcache_line_store
    import dcache_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  index_t  index,
    output logic    line_valid,
    output logic    line_dirty,
    output tag_t    line_tag,
    output line_t   line_data,
    input  logic    word_we,
    input  offset_t word_offset,
    input  word_t   word_data,
    input  logic    set_dirty,
    input  logic    fill,
    input  tag_t    fill_tag
);

    line_t            data_q [LINES];
    tag_t             tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;

    assign line_valid = valid_q[index];
    assign line_dirty = dirty_q[index];
    assign line_tag   = tag_q[index];
    assign line_data  = data_q[index];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we && set_dirty) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Data and tags carry no reset: valid_q gates every use of them.
    always_ff @(posedge clock) begin
        if (word_we) begin
            data_q[index][word_offset] <= word_data;
        end
        if (fill) begin
            tag_q[index] <= fill_tag;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete with no stall; a miss stalls the CPU while a dirty victim is
// written back and the line is refilled, one memory word per transfer.
//   clock, reset  clock; asynchronous active-high reset
//   cpu           CPU load/store port (cache is the slave)
//   mem           data memory port (cache is the master)
module dcache_controller
    import dcache_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    dcache_if.slave  cpu,
    dcache_if.master mem
);

    state_t  state_q;
    offset_t cnt_q;
    logic    armed_q;  // strobe has been seen high at an edge for the current word

    tag_t    req_tag;
    index_t  req_index;
    offset_t req_offset;
    logic    req, hit, xfer_done, last_word;
    offset_t next_cnt;

    logic    line_valid, line_dirty;
    tag_t    line_tag;
    line_t   line_data;
    logic    word_we, set_dirty, fill;
    offset_t word_offset;
    word_t   word_data;

    assign req_tag    = addr_tag(cpu.address);
    assign req_index  = addr_index(cpu.address);
    assign req_offset = addr_offset(cpu.address);

    // Read and write together is illegal and treated as no request.
    assign req       = cpu.read ^ cpu.write;
    assign hit       = line_valid && (line_tag == req_tag);
    assign xfer_done = armed_q && !mem.busywait;
    assign last_word = (cnt_q == offset_t'(WORDS_PER_LINE - 1));
    assign next_cnt  = cnt_q + offset_t'(1);

    assign cpu.busywait = !reset && ((state_q != IDLE) || (req && !hit));
    assign cpu.readdata = (state_q == IDLE && cpu.read && !cpu.write && hit)
                        ? line_data[req_offset] : '0;

    always_comb begin
        word_we     = 1'b0;
        set_dirty   = 1'b0;
        fill        = 1'b0;
        word_offset = req_offset;
        word_data   = cpu.writedata;
        if (state_q == IDLE) begin
            if (req && hit && cpu.write) begin
                word_we   = 1'b1;
                set_dirty = 1'b1;
            end
        end else if (state_q == FETCH && xfer_done) begin
            word_we     = 1'b1;
            word_offset = cnt_q;
            word_data   = mem.readdata;
            fill        = last_word;
        end
    end

    dcache_line_store u_store (
        .clock       (clock),
        .reset       (reset),
        .index       (req_index),
        .line_valid  (line_valid),
        .line_dirty  (line_dirty),
        .line_tag    (line_tag),
        .line_data   (line_data),
        .word_we     (word_we),
        .word_offset (word_offset),
        .word_data   (word_data),
        .set_dirty   (set_dirty),
        .fill        (fill),
        .fill_tag    (req_tag)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            armed_q       <= 1'b0;
            mem.read      <= 1'b0;
            mem.write     <= 1'b0;
            mem.address   <= '0;
            mem.writedata <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && !hit) begin
                        cnt_q   <= '0;
                        armed_q <= 1'b0;
                        if (line_valid && line_dirty) begin
                            state_q       <= WRITEBACK;
                            mem.write     <= 1'b1;
                            mem.address   <= make_addr(line_tag, req_index, '0);
                            mem.writedata <= line_data[0];
                        end else begin
                            state_q     <= FETCH;
                            mem.read    <= 1'b1;
                            mem.address <= make_addr(req_tag, req_index, '0);
                        end
                    end
                end
                WRITEBACK: begin
                    if (xfer_done) begin
                        armed_q <= 1'b0;
                        if (last_word) begin
                            cnt_q       <= '0;
                            state_q     <= FETCH;
                            mem.write   <= 1'b0;
                            mem.read    <= 1'b1;
                            mem.address <= make_addr(req_tag, req_index, '0);
                        end else begin
                            cnt_q         <= next_cnt;
                            mem.address   <= make_addr(line_tag, req_index, next_cnt);
                            mem.writedata <= line_data[next_cnt];
                        end
                    end else begin
                        armed_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (xfer_done) begin
                        armed_q <= 1'b0;
                        if (last_word) begin
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                            mem.read    <= 1'b0;
                            mem.address <= '0;
                        end else begin
                            cnt_q       <= next_cnt;
                            mem.address <= make_addr(req_tag, req_index, next_cnt);
                        end
                    end else begin
                        armed_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed vector table, a reset
// mid-refill sequence, and randomized loads/stores against a behavioural
// cache + memory model.
module tb_dcache_controller;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    dcache_if cpu_bus ();
    dcache_if mem_bus ();

    dcache_controller dut (
        .clock (clock),
        .reset (reset),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
    );

    typedef struct packed {
        logic        is_write;
        logic [5:0]  addr;
        logic [31:0] data;
    } xfer_t;

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- memory responder ----------------
    bit [31:0] mem_array [64];
    xfer_t     xfer_log [$];
    int        busy_cnt;
    bit        mem_armed;
    int        strobe_cycles = 0;
    int        strobe_clash  = 0;

    assign mem_bus.readdata = mem_array[mem_bus.address];
    assign mem_bus.busywait = (mem_bus.read || mem_bus.write) && (busy_cnt != 0);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_armed <= 1'b0;
            busy_cnt  <= 0;
        end else if (mem_bus.read || mem_bus.write) begin
            strobe_cycles <= strobe_cycles + 1;
            if (mem_bus.read && mem_bus.write) strobe_clash <= strobe_clash + 1;
            if (mem_armed && busy_cnt == 0) begin
                if (mem_bus.write) mem_array[mem_bus.address] <= mem_bus.writedata;
                xfer_log.push_back({mem_bus.write, mem_bus.address,
                                    mem_bus.write ? mem_bus.writedata : mem_array[mem_bus.address]});
                mem_armed <= 1'b0;
                busy_cnt  <= $urandom_range(0, 2);
            end else begin
                mem_armed <= 1'b1;
                if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            end
        end else begin
            mem_armed <= 1'b0;
        end
    end

    // ---------------- reference model ----------------
    bit        r_valid [8];
    bit        r_dirty [8];
    int        r_tag   [8];
    bit [31:0] r_data  [8][2];
    bit [31:0] r_mem   [64];
    xfer_t     exp_q   [$];

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) begin
            r_valid[i] = 0;
            r_dirty[i] = 0;
        end
    endtask

    task automatic ref_op(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] wd,
                          output bit miss, output logic [31:0] rdata);
        int ai, idx, tg, off, base;
        ai = int'(a);
        off = ai % 2;
        idx = (ai / 2) % 8;
        tg = ai / 16;
        exp_q.delete();
        miss = 0;
        rdata = '0;
        if (rd == wr) return;
        if (!(r_valid[idx] && r_tag[idx] == tg)) begin
            miss = 1;
            if (r_valid[idx] && r_dirty[idx]) begin
                base = r_tag[idx] * 16 + idx * 2;
                for (int w = 0; w < 2; w++) begin
                    r_mem[base + w] = r_data[idx][w];
                    exp_q.push_back({1'b1, 6'(base + w), r_data[idx][w]});
                end
            end
            base = tg * 16 + idx * 2;
            for (int w = 0; w < 2; w++) begin
                r_data[idx][w] = r_mem[base + w];
                exp_q.push_back({1'b0, 6'(base + w), r_mem[base + w]});
            end
            r_valid[idx] = 1;
            r_dirty[idx] = 0;
            r_tag[idx] = tg;
        end
        if (wr) begin
            r_data[idx][off] = wd;
            r_dirty[idx] = 1;
        end else begin
            rdata = r_data[idx][off];
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic cpu_op(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] wd,
                          output bit stalled, output logic [31:0] rdata, output bit timed_out);
        int n;
        @(negedge clock);
        cpu_bus.read = rd;
        cpu_bus.write = wr;
        cpu_bus.address = a;
        cpu_bus.writedata = wd;
        #1;
        stalled = cpu_bus.busywait;
        n = 0;
        while (cpu_bus.busywait && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        timed_out = (n >= 200);
        rdata = cpu_bus.readdata;
        @(negedge clock);
        cpu_bus.read = 1'b0;
        cpu_bus.write = 1'b0;
    endtask

    task automatic run_op(input string name, input bit rd, input bit wr, input logic [5:0] a,
                          input logic [31:0] wd, output bit stalled, output logic [31:0] rdata,
                          output int nw, output int nr);
        bit exp_miss, timed_out;
        logic [31:0] exp_rd;
        int start, s_start, got;
        ref_op(rd, wr, a, wd, exp_miss, exp_rd);
        start = xfer_log.size();
        s_start = strobe_cycles;
        cpu_op(rd, wr, a, wd, stalled, rdata, timed_out);
        chk({name, " timeout"}, 64'(timed_out), 64'd0);
        chk({name, " stall"}, 64'(stalled), 64'(exp_miss));
        if (rd && !wr) chk({name, " rdata"}, 64'(rdata), 64'(exp_rd));
        if (!exp_miss) chk({name, " quiet_bus"}, 64'(strobe_cycles - s_start), 64'd0);
        got = xfer_log.size() - start;
        chk({name, " xfer_count"}, 64'(got), 64'(exp_q.size()));
        nw = 0;
        nr = 0;
        for (int i = 0; i < got; i++) begin
            if (xfer_log[start + i].is_write) nw++;
            else nr++;
            if (i < exp_q.size())
                chk($sformatf("%s xfer%0d", name, i), 64'(xfer_log[start + i]), 64'(exp_q[i]));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        bit          stall;
        int          nw;
        int          nr;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        bit          stalled;
        logic [31:0] rdata;
        int          nw, nr, n, start;
        bit          r, w;
        int          sel;

        vecs[0]  = '{1, 0, 6'h05, 32'h0,        1, 0, 2, 32'h0};        // cold read miss
        vecs[1]  = '{0, 1, 6'h05, 32'hDEADBEEF, 0, 0, 0, 32'h0};        // write hit
        vecs[2]  = '{1, 0, 6'h05, 32'h0,        0, 0, 0, 32'hDEADBEEF}; // read back
        vecs[3]  = '{1, 0, 6'h15, 32'h0,        1, 2, 2, 32'h0};        // dirty eviction
        vecs[4]  = '{1, 0, 6'h05, 32'h0,        1, 0, 2, 32'hDEADBEEF}; // clean refill
        vecs[5]  = '{1, 0, 6'h00, 32'h0,        1, 0, 2, 32'h0};
        vecs[6]  = '{1, 0, 6'h30, 32'h0,        1, 0, 2, 32'h0};        // clean eviction
        vecs[7]  = '{1, 1, 6'h05, 32'h12345678, 0, 0, 0, 32'h0};        // illegal
        vecs[8]  = '{1, 0, 6'h05, 32'h0,        0, 0, 0, 32'hDEADBEEF}; // unchanged
        vecs[9]  = '{0, 1, 6'h30, 32'hCAFEF00D, 0, 0, 0, 32'h0};
        vecs[10] = '{1, 0, 6'h31, 32'h0,        0, 0, 0, 32'h0};

        cpu_bus.read = 1'b0;
        cpu_bus.write = 1'b0;
        cpu_bus.address = '0;
        cpu_bus.writedata = '0;
        ref_reset();

        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset busywait", 64'(cpu_bus.busywait), 64'd0);
        chk("reset mem_read", 64'(mem_bus.read), 64'd0);
        chk("reset mem_write", 64'(mem_bus.write), 64'd0);
        chk("reset mem_address", 64'(mem_bus.address), 64'd0);
        chk("reset mem_writedata", 64'(mem_bus.writedata), 64'd0);
        chk("reset readdata", 64'(cpu_bus.readdata), 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   stalled, rdata, nw, nr);
            chk($sformatf("vec%0d tbl_stall", i), 64'(stalled), 64'(vecs[i].stall));
            chk($sformatf("vec%0d tbl_nw", i), 64'(nw), 64'(vecs[i].nw));
            chk($sformatf("vec%0d tbl_nr", i), 64'(nr), 64'(vecs[i].nr));
            if (vecs[i].rd && !vecs[i].wr)
                chk($sformatf("vec%0d tbl_rdata", i), 64'(rdata), 64'(vecs[i].rdata));
        end

        // Reset during the second word of a refill.
        start = xfer_log.size();
        @(negedge clock);
        cpu_bus.read = 1'b1;
        cpu_bus.address = 6'h09;
        n = 0;
        while (!(mem_bus.read && mem_bus.address == 6'h09) && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("rstfetch reached_word1", 64'(n < 100), 64'd1);
        chk("rstfetch words_done", 64'(xfer_log.size() - start), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstfetch mem_read", 64'(mem_bus.read), 64'd0);
        chk("rstfetch mem_write", 64'(mem_bus.write), 64'd0);
        chk("rstfetch busywait", 64'(cpu_bus.busywait), 64'd0);
        cpu_bus.read = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        ref_reset();
        run_op("rstfetch reread", 1, 0, 6'h09, 32'h0, stalled, rdata, nw, nr);
        chk("rstfetch reread_missed", 64'(stalled), 64'd1);

        // Randomized loads/stores, with occasional illegal read+write.
        for (int k = 0; k < 250; k++) begin
            sel = $urandom_range(0, 19);
            r = (sel < 10) || (sel == 19);
            w = (sel >= 10);
            run_op($sformatf("rand%0d", k), r, w, 6'($urandom), $urandom, stalled, rdata, nw, nr);
        end

        chk("strobes never both high", 64'(strobe_clash), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
